sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Digital successive-approximation controller that closes the loop around the on-chip OTA/comparator stage.
- Drives an N-bit trial code to the capacitive/resistive DAC feeding the comparator's inverting input.
- Consumes the comparator decision on a digital pin and produces a binary conversion result with a done strobe.
- Sits directly downstream of the comparator output and upstream of the DAC, in the same tile as the OTA.

Parameters:
- WIDTH, 8, number of result/DAC bits (legal 2..8).
- SAMPLE_CYC, 4, clock cycles sample_en is held high for input acquisition (legal 1..15).
- SETTLE, 4, cycles per bit trial, covering DAC settling, comparator delay and the 2-flop synchronizer (legal 3..15; anything below 3 is a configuration error flagged by a simulation assertion).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a conversion; level-sampled in IDLE and DONE only.
- cmp_in  in  1  raw comparator output, asynchronous to clk; 1 means analog input >= DAC voltage.
- sample_en  out  1  high during the acquisition window (closes the sampling switch).
- dac_code  out  WIDTH  trial code to the DAC.
- busy  out  1  high in SAMPLE and CONVERT.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  last completed conversion; held until the next done.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; sample_en=0, busy=0, done=0, dac_code=0, result=0; synchronizer flops=0; all counters=0.
- cmp_in passes through a 2-flop synchronizer (cmp_s). No logic uses cmp_in directly.
- IDLE: start=1 at edge k moves to SAMPLE at k+1.
- SAMPLE: sample_en=1 and busy=1 for exactly SAMPLE_CYC cycles. dac_code holds its previous value. On exit, dac_code = 1<<(WIDTH-1), the kept bits clear, and the bit index = WIDTH-1.
- CONVERT: busy=1, sample_en=0. Each bit i occupies exactly SETTLE cycles.
  - In the last cycle of the window, cmp_s is evaluated: 1 keeps bit i, 0 clears it.
  - At the same edge, if i>0, dac_code = kept bits | (1<<(i-1)).
  - If i=0, the final code is loaded into result and into dac_code, and the state moves to DONE.
- DONE: exactly one cycle; done=1, busy=0. result is valid in this cycle.
  - start=1 in DONE goes straight to SAMPLE (back-to-back conversions).
  - Otherwise the state returns to IDLE.
- Latency: start accepted at edge k gives done high in cycle k+1+SAMPLE_CYC+WIDTH*SETTLE. With defaults that is k+37.
- start in SAMPLE or CONVERT is ignored. There is no queueing and no abort.
- dac_code holds the final result in IDLE until the next trial sequence begins.
- Reset mid-conversion: immediate return to reset values, including result=0. No done pulse is produced.
- cmp_s stuck at 1 yields all-ones; stuck at 0 yields all-zeros. There is no overflow or wrap.

Test Plan:
- Ideal comparator model (cmp_in = vin >= dac_code, updated combinationally), vin=0xA5, start pulse: dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6, each held 4 cycles, then 0xA5; done exactly 37 cycles after start is accepted; result=0xA5.
- Boundary codes vin=0x00 and vin=0xFF: result 0x00 and 0xFF respectively; done high for 1 cycle; busy low again the following cycle.
- start held high continuously with vin changing 0x3C then 0xC3 between conversions: back-to-back conversions with no IDLE cycle; sample_en rises the cycle after each done; results 0x3C then 0xC3.
- start pulsed during CONVERT: ignored; exactly one done, after 37 cycles; result unchanged by the extra pulse.
- rst_n asserted for 1 cycle mid-conversion (5th bit trial): all outputs go to 0 immediately, no done, result=0; a new start then converts correctly.
- Randomized cmp_in edges injected 0.3 cycles before the clock edge, plus a parameter sweep of WIDTH=4 and SETTLE=3: no X propagation; latency = 1+SAMPLE_CYC+WIDTH*SETTLE; result matches the model for 500 random vin.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller for the comparator/DAC loop.
//
// Each conversion samples the input for SAMPLE_CYC cycles and then resolves one
// bit per SETTLE-cycle window, MSB first. The comparator decision is taken
// through a 2-flop synchronizer in the last cycle of every window.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   start      conversion request, level-sampled in IDLE and DONE only
//   cmp_in     raw comparator output, asynchronous; 1 = vin >= DAC voltage
//   sample_en  high during the acquisition window
//   dac_code   trial code to the DAC; holds the final result while idle
//   busy       high in SAMPLE and CONVERT
//   done       one-cycle pulse, result valid in that cycle
//   result     last completed conversion, held until the next done
//
// Handshake: start is a level request with no ready signal; it is honoured
// only when busy is low (IDLE, or the DONE cycle for back-to-back operation)
// and dropped silently otherwise. done is a single-cycle valid with no
// back-pressure; result stays stable after it until the next done.
module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0]    SAMPLE_LAST = 4'(SAMPLE_CYC - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [IW-1:0] MSB_IDX     = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             cmp_meta, cmp_s;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] bit_mask, decided;

    // Two-flop synchronizer; cmp_in is never used anywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        code_d   = code_q;
        result_d = result_q;
        // code_q always carries the kept upper bits plus the bit under trial,
        // so deciding a bit only ever needs to clear it.
        bit_mask = WIDTH'(1) << idx_q;
        decided  = cmp_s ? code_q : (code_q & ~bit_mask);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                    idx_d   = MSB_IDX;
                    code_d  = WIDTH'(1) << (WIDTH - 1);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CONVERT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        code_d   = decided;
                        result_d = decided;
                        state_d  = S_DONE;
                    end else begin
                        code_d = decided | (bit_mask >> 1);
                        idx_d  = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = start ? S_SAMPLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sample_en = (state_q == S_SAMPLE);
    assign busy      = (state_q == S_SAMPLE) || (state_q == S_CONVERT);
    assign done      = (state_q == S_DONE);
    assign dac_code  = code_q;
    assign result    = result_q;

    // Fewer than three cycles per trial cannot cover the synchronizer delay.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (SETTLE >= 3)
            else $error("sar_adc_ctrl: SETTLE=%0d is below 3", SETTLE);
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: a default-size instance (8 bit, settle 4) checked
// cycle by cycle against a timeline model, and a WIDTH=4 / SETTLE=3 instance
// checked on every done. An ideal comparator closes the loop; in the random
// phases the comparator output carries junk for most of each cycle and only
// becomes valid 0.3 cycles before the next clock edge.
module tb_sar_adc_ctrl;

    localparam int W   = 8;
    localparam int SC  = 4;
    localparam int ST  = 4;
    localparam int LAT = SC + W * ST;    // edges from accepting edge to done cycle
    localparam int WB  = 4;
    localparam int STB = 3;
    localparam int LATB = SC + WB * STB;

    // ---------------- clock / reset / signals ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;
    logic [W-1:0]  vin   = '0;
    logic [WB-1:0] vin_b = '0;
    logic glitch   = 1'b0;
    logic cmp_hold = 1'b0;
    logic cmp_junk = 1'b0;
    logic cmp_in, cmp_in_b;

    logic          sample_en, busy, done;
    logic [W-1:0]  dac_code, result;
    logic          sample_en_b, busy_b, done_b;
    logic [WB-1:0] dac_code_b, result_b;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYC(SC), .SETTLE(ST)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmp_in(cmp_in),
        .sample_en(sample_en), .dac_code(dac_code), .busy(busy),
        .done(done), .result(result)
    );

    sar_adc_ctrl #(.WIDTH(WB), .SAMPLE_CYC(SC), .SETTLE(STB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cmp_in(cmp_in_b),
        .sample_en(sample_en_b), .dac_code(dac_code_b), .busy(busy_b),
        .done(done_b), .result(result_b)
    );

    // Comparator: ideal, except that in glitch mode the output is random
    // from 0.1 to 0.7 cycles after each edge.
    always @(posedge clk) begin
        if (glitch) begin
            #1;
            cmp_junk = 1'($urandom_range(0, 1));
            cmp_hold = 1'b1;
            #6;
            cmp_hold = 1'b0;
        end
    end
    assign cmp_in   = cmp_hold ? cmp_junk  : (vin >= dac_code);
    assign cmp_in_b = cmp_hold ? ~cmp_junk : (vin_b >= dac_code_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor, instance A ----------------
    logic [W-1:0] exp_q[$];
    int           exp_t[$];
    logic         m_act = 1'b0;
    int           s_cyc = 0;
    int           d_cyc = 0;
    logic [W-1:0] cv = '0;
    logic [W-1:0] last_code = '0;
    logic [W-1:0] last_res  = '0;

    always @(negedge clk) begin : mon_a
        logic         e_se, e_busy, e_done;
        logic [W-1:0] e_dac, e_res, r;
        int           i, cvi, t;
        if (!rst_n) begin
            chk("reset_outputs", 32'({sample_en, busy, done, dac_code, result}), 32'd0);
            m_act = 1'b0;
            last_code = '0;
            last_res  = '0;
            exp_q.delete();
            exp_t.delete();
        end else begin
            e_se = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_dac = last_code;
            e_res = last_res;
            if (m_act) begin
                if (cyc < s_cyc + SC) begin
                    e_se = 1'b1;
                    e_busy = 1'b1;
                end else if (cyc < d_cyc) begin
                    // bit i under trial: bits above i equal vin, bit i set, rest clear
                    e_busy = 1'b1;
                    i   = W - 1 - (cyc - s_cyc - SC) / ST;
                    cvi = int'(cv);
                    e_dac = W'(((cvi >> (i + 1)) << (i + 1)) | (1 << i));
                end else begin
                    e_done = 1'b1;
                    e_dac  = cv;
                    e_res  = cv;
                end
            end
            chk("no_x", 32'($isunknown({sample_en, busy, done, dac_code, result})), 32'd0);
            chk("sample_en", 32'(sample_en), 32'(e_se));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("dac_code", 32'(dac_code), 32'(e_dac));
            chk("result_hold", 32'(result), 32'(e_res));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    t = exp_t.pop_front();
                    chk("sb_result", 32'(result), 32'(r));
                    chk("sb_latency", 32'(cyc), 32'(t));
                end
            end
            if (m_act && cyc >= d_cyc) begin
                last_code = cv;
                last_res  = cv;
                m_act = 1'b0;
            end
            if (start && !m_act) begin
                m_act = 1'b1;
                s_cyc = cyc + 1;
                d_cyc = cyc + 1 + LAT;
                cv    = vin;
                exp_q.push_back(vin);
                exp_t.push_back(d_cyc);
            end
        end
    end

    // ---------------- scoreboard / monitor, instance B ----------------
    logic [WB-1:0] exp_qb[$];
    int            exp_tb[$];
    logic          b_act = 1'b0;
    int            b_d = 0;

    always @(negedge clk) begin : mon_b
        logic [WB-1:0] r;
        int            t;
        if (!rst_n) begin
            b_act = 1'b0;
            exp_qb.delete();
            exp_tb.delete();
        end else begin
            chk("b_no_x", 32'($isunknown({sample_en_b, busy_b, done_b, dac_code_b, result_b})), 32'd0);
            chk("b_busy", 32'(busy_b), 32'(b_act && cyc < b_d));
            if (done_b === 1'b1) begin
                if (exp_qb.size() == 0) begin
                    chk("b_spurious_done", 32'd1, 32'd0);
                end else begin
                    r = exp_qb.pop_front();
                    t = exp_tb.pop_front();
                    chk("b_sb_result", 32'(result_b), 32'(r));
                    chk("b_sb_latency", 32'(cyc), 32'(t));
                end
            end
            if (b_act && cyc >= b_d) b_act = 1'b0;
            if (start_b && !b_act) begin
                b_act = 1'b1;
                b_d   = cyc + 1 + LATB;
                exp_qb.push_back(vin_b);
                exp_tb.push_back(b_d);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick(1);
            k++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done_b(input int limit);
        int k = 0;
        while (done_b !== 1'b1 && k < limit) begin
            tick(1);
            k++;
        end
        if (done_b !== 1'b1) chk("b_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input logic [W-1:0] v);
        vin   = v;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(LAT + 10);
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(2);

        // single conversion, then the boundary codes
        convert(8'hA5);
        tick(3);
        convert(8'h00);
        convert(8'hFF);
        tick(2);

        // start held high: back-to-back conversions
        vin   = 8'h3C;
        start = 1'b1;
        tick(1);
        wait_done(LAT + 10);
        vin = 8'hC3;
        tick(1);
        wait_done(LAT + 10);
        start = 1'b0;
        tick(3);

        // extra start pulse during CONVERT is ignored
        vin   = 8'h5A;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(LAT + 10);
        tick(LAT + 5);

        // reset during the fifth bit trial
        vin   = 8'h5C;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(SC + 4 * ST + 1);
        rst_n = 1'b0;
        #1;
        chk("reset_immediate", 32'({sample_en, busy, done, dac_code, result}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(LAT + 5);
        convert(8'h77);

        // random codes with late-settling comparator
        glitch = 1'b1;
        for (int n = 0; n < 500; n++) begin
            vin   = 8'($urandom_range(0, 255));
            start = 1'b1;
            tick(1);
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                tick(5 + $urandom_range(0, 20));
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            wait_done(LAT + 10);
            tick($urandom_range(0, 2));
        end
        tick(2);

        // narrow / fast instance
        for (int n = 0; n < 500; n++) begin
            vin_b   = 4'($urandom_range(0, 15));
            start_b = 1'b1;
            tick(1);
            start_b = 1'b0;
            wait_done_b(LATB + 10);
            tick($urandom_range(0, 2));
        end
        glitch = 1'b0;
        tick(5);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
